// File: rtl/pir_ctrl_pkg.sv
// rtl/pir_ctrl_pkg.sv - shared state encoding and default timing constants for the PIR light controller
package pir_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_WARMUP   = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_COOLDOWN = 2'd3
    } pir_state_e;

    // Defaults for a 32 MHz system clock
    localparam int DEF_DEBOUNCE_LEN    = 4;
    localparam int DEF_WARMUP_CYCLES   = 960_000_000;
    localparam int DEF_HOLD_CYCLES     = 320_000_000;
    localparam int DEF_BLINK_HALF      = 16_000_000;
    localparam int DEF_COOLDOWN_CYCLES = 64_000_000;
    localparam int DEF_CNT_W           = 32;
    localparam int DEF_EVT_W           = 16;

endpackage

// File: rtl/pir_debounce.sv
// rtl/pir_debounce.sv - PIR input synchroniser, shift-register debouncer and rising-edge pulse
module pir_debounce #(
    parameter int DEBOUNCE_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pir_i,
    output logic level_o,
    output logic pulse_o
);

    logic [1:0]              sync_q;
    logic [DEBOUNCE_LEN-1:0] sh_q;
    logic [DEBOUNCE_LEN-1:0] sh_d;
    logic                    level_q;
    logic                    level_d;
    logic                    prev_q;
    logic                    pulse_q;

    // Level is decided on the incoming shift value so the total latency is sync depth plus window length
    always_comb begin
        sh_d    = {sh_q[DEBOUNCE_LEN-2:0], sync_q[1]};
        level_d = level_q;
        if (&sh_d) begin
            level_d = 1'b1;
        end else if (~|sh_d) begin
            level_d = 1'b0;
        end
    end

    // Synchroniser, debounce window, level and a one-cycle-delayed rising-edge pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            sh_q    <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pir_i};
            sh_q    <= sh_d;
            level_q <= level_d;
            prev_q  <= level_q;
            pulse_q <= level_q & ~prev_q;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/pir_light_controller.sv
// rtl/pir_light_controller.sv - warm-up, retriggerable blinking hold and cooldown sequencing of the PIR LED
module pir_light_controller
    import pir_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LEN    = DEF_DEBOUNCE_LEN,
    parameter int WARMUP_CYCLES   = DEF_WARMUP_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int BLINK_HALF      = DEF_BLINK_HALF,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int EVT_W           = DEF_EVT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pir_output,
    input  logic               enable,
    output logic               internal_led,
    output logic               motion_level,
    output logic               motion_pulse,
    output logic [STATE_W-1:0] state,
    output logic [EVT_W-1:0]   event_count
);

    localparam logic [CNT_W-1:0] WARM_TC  = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_TC = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] COOL_TC  = CNT_W'(COOLDOWN_CYCLES - 1);

    pir_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] blink_q, blink_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic             led_q, led_d;
    logic             level;

    pir_debounce #(
        .DEBOUNCE_LEN(DEBOUNCE_LEN)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .pir_i  (pir_output),
        .level_o(level),
        .pulse_o(motion_pulse)
    );

    // State, shared timer, blink phase, event counter and LED registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_WARMUP;
            timer_q <= '0;
            blink_q <= '0;
            evt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
            evt_q   <= evt_d;
            led_q   <= led_d;
        end
    end

    // Next state and shared timer; a retrigger in ACTIVE takes priority over hold expiry
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        evt_d   = evt_q;
        case (state_q)
            ST_WARMUP: begin
                if (timer_q == WARM_TC) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                timer_d = '0;
                if (enable && level) begin
                    state_d = ST_ACTIVE;
                    if (evt_q != {EVT_W{1'b1}}) begin
                        evt_d = evt_q + EVT_W'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (level) begin
                    timer_d = '0;
                end else if (timer_q == HOLD_TC) begin
                    state_d = ST_COOLDOWN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (!enable || (timer_q == COOL_TC)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_WARMUP;
                timer_d = '0;
            end
        endcase
    end

    // LED and blink phase: on at ACTIVE entry, toggled each half period, off outside ACTIVE
    always_comb begin
        blink_d = '0;
        led_d   = 1'b0;
        if (state_d == ST_ACTIVE) begin
            if (state_q != ST_ACTIVE) begin
                led_d = 1'b1;
            end else if (blink_q == BLINK_TC) begin
                led_d = ~led_q;
            end else begin
                led_d   = led_q;
                blink_d = blink_q + CNT_W'(1);
            end
        end
    end

    assign internal_led = led_q;
    assign motion_level = level;
    assign state        = state_q;
    assign event_count  = evt_q;

endmodule

// File: tb/tb_pir_light_controller.sv
// tb/tb_pir_light_controller.sv - randomized self-checking bench for pir_light_controller
module tb_pir_light_controller;

    localparam int L    = 4;
    localparam int WARM = 20;
    localparam int HOLD = 30;
    localparam int BH   = 4;
    localparam int COOL = 10;
    localparam int EW   = 4;
    localparam int EMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pir_output = 1'b0;
    logic          enable = 1'b0;
    logic          internal_led;
    logic          motion_level;
    logic          motion_pulse;
    logic [1:0]    state;
    logic [EW-1:0] event_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: phases described by the cycle they started at
    int m_state = 0;
    int m_k = 0;
    int m_act = 0;
    int m_last = 0;
    int m_cd = 0;
    int m_evt = 0;
    int m_led = 0;
    int m_lvl = 0;
    int m_lvl_prev = 0;
    int m_pulse = 0;
    int hist[L+2];

    pir_light_controller #(
        .DEBOUNCE_LEN   (L),
        .WARMUP_CYCLES  (WARM),
        .HOLD_CYCLES    (HOLD),
        .BLINK_HALF     (BH),
        .COOLDOWN_CYCLES(COOL),
        .CNT_W          (32),
        .EVT_W          (EW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pir_output  (pir_output),
        .enable      (enable),
        .internal_led(internal_led),
        .motion_level(motion_level),
        .motion_pulse(motion_pulse),
        .state       (state),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        int all1;
        int all0;
        if (!rst_n) begin
            m_state = 0; m_k = 0; m_evt = 0; m_led = 0;
            m_lvl = 0; m_lvl_prev = 0; m_pulse = 0;
            foreach (hist[i]) hist[i] = 0;
        end else begin
            m_k++;
            case (m_state)
                0: if (m_k == WARM) m_state = 1;
                1: if (enable && m_lvl == 1) begin
                       m_state = 2; m_act = m_k; m_last = m_k;
                       if (m_evt < EMAX) m_evt++;
                   end
                2: if (!enable) m_state = 1;
                   else if (m_lvl == 1) m_last = m_k;
                   else if (m_k - m_last == HOLD) begin m_state = 3; m_cd = m_k; end
                default: if (!enable || (m_k - m_cd == COOL)) m_state = 1;
            endcase
            m_led = (m_state == 2 && ((m_k - m_act) / BH) % 2 == 0) ? 1 : 0;
            for (int i = L + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(pir_output);
            all1 = 1; all0 = 1;
            for (int i = 2; i <= L + 1; i++) begin
                if (hist[i] != 1) all1 = 0;
                if (hist[i] != 0) all0 = 0;
            end
            m_pulse = (m_lvl == 1 && m_lvl_prev == 0) ? 1 : 0;
            m_lvl_prev = m_lvl;
            if (all1 == 1) m_lvl = 1;
            else if (all0 == 1) m_lvl = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("state", 32'(state), 32'(m_state));
        check("led", 32'(internal_led), 32'(m_led));
        check("level", 32'(motion_level), 32'(m_lvl));
        check("pulse", 32'(motion_pulse), 32'(m_pulse));
        check("evt", 32'(event_count), 32'(m_evt));
    endtask

    task automatic wait_state(input int st, input int lim, input string tag);
        int n;
        n = 0;
        while (m_state != st && n < lim) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(st));
    endtask

    initial begin
        int n;
        int left;
        int len;

        // Reset held while motion is present, then warm-up with motion ignored
        rst_n = 1'b0; enable = 1'b1; pir_output = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (19) tick();
        check("warmup_hold", 32'(state), 32'd0);
        repeat (2) tick();
        check("active_after_warmup", 32'(state), 32'd2);
        repeat (3) tick();

        // Motion during cooldown is ignored, then ACTIVE right after IDLE
        pir_output = 1'b0;
        wait_state(3, 200, "reach_cooldown");
        pir_output = 1'b1;
        repeat (25) tick();
        check("active_after_cooldown", 32'(state), 32'd2);
        pir_output = 1'b0;
        repeat (60) tick();
        check("idle_after_cycle", 32'(state), 32'd1);

        // Short glitches must not reach motion_level
        for (int g = 1; g <= 3; g++) begin
            pir_output = 1'b1;
            repeat (g) tick();
            pir_output = 1'b0;
            repeat ($urandom_range(6, 12)) tick();
        end
        check("glitch_idle", 32'(state), 32'd1);

        // Retrigger landing exactly on the hold terminal count
        pir_output = 1'b1;
        wait_state(2, 50, "reach_active");
        pir_output = 1'b0;
        n = 0;
        while (!(m_state == 2 && m_lvl == 0 && m_k - m_last == HOLD - 7) && n < 200) begin
            tick();
            n++;
        end
        check("retrigger_setup", 32'(n < 200), 32'd1);
        pir_output = 1'b1;
        repeat (6) tick();
        check("retrigger_active", 32'(state), 32'd2);
        pir_output = 1'b0;
        repeat (60) tick();

        // enable drop mid-ACTIVE, then reset mid-ACTIVE
        pir_output = 1'b1;
        wait_state(2, 50, "reach_active2");
        enable = 1'b0;
        tick();
        check("disable_idle", 32'(state), 32'd1);
        check("disable_led", 32'(internal_led), 32'd0);
        enable = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("reset_state", 32'(state), 32'd0);
        check("reset_led", 32'(internal_led), 32'd0);
        rst_n = 1'b1;
        pir_output = 1'b0;
        repeat (25) tick();

        // Randomized runs of motion with occasional enable drops and resets
        left = 2000;
        while (left > 0) begin
            len = $urandom_range(1, 40);
            pir_output = 1'($urandom_range(0, 1));
            repeat (len) begin
                enable = ($urandom_range(0, 49) != 0);
                rst_n  = ($urandom_range(0, 599) != 0);
                tick();
                left--;
            end
        end
        rst_n = 1'b1; enable = 1'b1;

        // Event counter saturation after a fresh reset
        rst_n = 1'b0; pir_output = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (22) tick();
        for (int a = 0; a < 18; a++) begin
            pir_output = 1'b1;
            repeat (8) tick();
            check("evt_n", 32'(event_count), 32'((a + 1 > EMAX) ? EMAX : a + 1));
            pir_output = 1'b0;
            repeat (60) tick();
        end
        check("evt_sat", 32'(event_count), 32'(EMAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
